// File: rtl/hemaia_mem_pkg.sv
// Shared types and helpers for the HeMAiA main-memory super-bank arbitration logic.
package hemaia_mem_pkg;

    typedef enum logic {
        OWN_WIDE   = 1'b0,
        OWN_NARROW = 1'b1
    } owner_e;

    // One slot of the response pipeline; the narrow grant mask travels alongside it.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } resp_entry_t;

    function automatic bit params_ok(
        input int unsigned wide_width,
        input int unsigned num_narrow,
        input int unsigned narrow_width,
        input int unsigned mem_latency,
        input int unsigned max_streak
    );
        return (wide_width == num_narrow * narrow_width) && (mem_latency >= 1) && (max_streak >= 1);
    endfunction

endpackage

// File: rtl/hemaia_resp_tracker.sv
// MemLatency-deep shift pipeline that turns request grants into response valids
// for the wide port or the matching narrow ports.
module hemaia_resp_tracker
    import hemaia_mem_pkg::*;
#(
    parameter int unsigned NumNarrow  = 8,
    parameter int unsigned MemLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wide_grant_i,
    input  logic [NumNarrow-1:0] narrow_grant_i,
    output logic                 wide_p_valid_o,
    output logic [NumNarrow-1:0] narrow_p_valid_o
);

    resp_entry_t          entry_q [MemLatency];
    logic [NumNarrow-1:0] mask_q  [MemLatency];
    resp_entry_t          entry_d;
    logic [NumNarrow-1:0] mask_d;

    always_comb begin
        entry_d.valid = wide_grant_i | (|narrow_grant_i);
        entry_d.owner = wide_grant_i ? OWN_WIDE : OWN_NARROW;
        mask_d        = wide_grant_i ? '0 : narrow_grant_i;
    end

    // Reset empties every stage so grants issued before reset never answer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MemLatency; i++) begin
                entry_q[i] <= '{valid: 1'b0, owner: OWN_WIDE};
                mask_q[i]  <= '0;
            end
        end else begin
            entry_q[0] <= entry_d;
            mask_q[0]  <= mask_d;
            for (int unsigned i = 1; i < MemLatency; i++) begin
                entry_q[i] <= entry_q[i-1];
                mask_q[i]  <= mask_q[i-1];
            end
        end
    end

    assign wide_p_valid_o   = entry_q[MemLatency-1].valid && (entry_q[MemLatency-1].owner == OWN_WIDE);
    assign narrow_p_valid_o = (entry_q[MemLatency-1].valid && (entry_q[MemLatency-1].owner == OWN_NARROW))
                              ? mask_q[MemLatency-1] : '0;

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Starvation-bounded arbiter between one wide port and NumNarrow narrow ports
// in front of a super-bank of SRAM, with response tracking.
module hemaia_superbank_arbiter
    import hemaia_mem_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned NumNarrow       = 8,
    parameter int unsigned AddrWidth       = 10,
    parameter int unsigned MemLatency      = 1,
    parameter int unsigned MaxWideStreak   = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   wide_q_valid_i,
    output logic                                   wide_q_ready_o,
    input  logic [AddrWidth-1:0]                   wide_q_addr_i,
    input  logic                                   wide_q_write_i,
    input  logic [WideDataWidth-1:0]               wide_q_data_i,
    input  logic [WideDataWidth/8-1:0]             wide_q_strb_i,
    output logic                                   wide_p_valid_o,
    output logic [WideDataWidth-1:0]               wide_p_data_o,
    input  logic [NumNarrow-1:0]                   narrow_q_valid_i,
    output logic [NumNarrow-1:0]                   narrow_q_ready_o,
    input  logic [NumNarrow*AddrWidth-1:0]         narrow_q_addr_i,
    input  logic [NumNarrow-1:0]                   narrow_q_write_i,
    input  logic [NumNarrow*NarrowDataWidth-1:0]   narrow_q_data_i,
    input  logic [NumNarrow*NarrowDataWidth/8-1:0] narrow_q_strb_i,
    output logic [NumNarrow-1:0]                   narrow_p_valid_o,
    output logic [NumNarrow*NarrowDataWidth-1:0]   narrow_p_data_o,
    output logic [NumNarrow-1:0]                   bank_cs_o,
    output logic [NumNarrow-1:0]                   bank_wen_o,
    output logic [NumNarrow*AddrWidth-1:0]         bank_addr_o,
    output logic [NumNarrow*NarrowDataWidth/8-1:0] bank_be_o,
    output logic [NumNarrow*NarrowDataWidth-1:0]   bank_wdata_o,
    input  logic [NumNarrow*NarrowDataWidth-1:0]   bank_rdata_i
);

    localparam int unsigned StrbW   = NarrowDataWidth / 8;
    localparam int unsigned StreakW = $clog2(MaxWideStreak + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxWideStreak);

    if (!params_ok(WideDataWidth, NumNarrow, NarrowDataWidth, MemLatency, MaxWideStreak)) begin : g_param_err
        $error("hemaia_superbank_arbiter: inconsistent parameters");
    end

    owner_e               owner;
    logic                 narrow_pend;
    logic                 wide_grant;
    logic [NumNarrow-1:0] narrow_grant;
    logic [StreakW-1:0]   streak_q;
    logic [StreakW-1:0]   streak_d;

    assign narrow_pend = |narrow_q_valid_i;

    // Wide keeps the super-bank until it has won MaxWideStreak times in a row over a waiting narrow.
    always_comb begin
        owner = OWN_NARROW;
        if (wide_q_valid_i && (!narrow_pend || (streak_q < StreakMax))) begin
            owner = OWN_WIDE;
        end
    end

    assign wide_grant       = (owner == OWN_WIDE);
    assign narrow_grant     = (owner == OWN_NARROW) ? narrow_q_valid_i : '0;
    assign wide_q_ready_o   = wide_grant;
    assign narrow_q_ready_o = narrow_grant;

    always_comb begin
        bank_cs_o    = '0;
        bank_wen_o   = '0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int unsigned j = 0; j < NumNarrow; j++) begin
            if (wide_grant) begin
                bank_cs_o[j]                                        = 1'b1;
                bank_wen_o[j]                                       = wide_q_write_i;
                bank_addr_o[j*AddrWidth +: AddrWidth]               = wide_q_addr_i;
                bank_be_o[j*StrbW +: StrbW]                         = wide_q_strb_i[j*StrbW +: StrbW];
                bank_wdata_o[j*NarrowDataWidth +: NarrowDataWidth]  = wide_q_data_i[j*NarrowDataWidth +: NarrowDataWidth];
            end else if (narrow_grant[j]) begin
                bank_cs_o[j]                                        = 1'b1;
                bank_wen_o[j]                                       = narrow_q_write_i[j];
                bank_addr_o[j*AddrWidth +: AddrWidth]               = narrow_q_addr_i[j*AddrWidth +: AddrWidth];
                bank_be_o[j*StrbW +: StrbW]                         = narrow_q_strb_i[j*StrbW +: StrbW];
                bank_wdata_o[j*NarrowDataWidth +: NarrowDataWidth]  = narrow_q_data_i[j*NarrowDataWidth +: NarrowDataWidth];
            end
        end
    end

    // Streak only grows while a narrow request is actually being held off.
    always_comb begin
        streak_d = '0;
        if (narrow_pend && wide_grant) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    hemaia_resp_tracker #(
        .NumNarrow  (NumNarrow),
        .MemLatency (MemLatency)
    ) i_resp_tracker (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wide_grant_i     (wide_grant),
        .narrow_grant_i   (narrow_grant),
        .wide_p_valid_o   (wide_p_valid_o),
        .narrow_p_valid_o (narrow_p_valid_o)
    );

    assign wide_p_data_o   = bank_rdata_i;
    assign narrow_p_data_o = bank_rdata_i;

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// Self-checking bench for hemaia_superbank_arbiter: hand-computed vector table,
// reset corner sequence and randomized traffic against a behavioural model.
module tb_hemaia_superbank_arbiter;

    localparam int NN   = 8;
    localparam int NDW  = 64;
    localparam int WDW  = 512;
    localparam int AW   = 10;
    localparam int LAT  = 3;
    localparam int MAXS = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wqv, wqw;
    logic [AW-1:0]  wqa;
    logic [WDW-1:0] wqd;
    logic [63:0]    wqs;
    logic [NN-1:0]  nqv, nqw;
    logic [NN*AW-1:0] nqa;
    logic [511:0]   nqd;
    logic [63:0]    nqs;
    logic [511:0]   rd_bus;

    logic           wide_q_ready_o, wide_p_valid_o;
    logic [511:0]   wide_p_data_o, narrow_p_data_o, bank_wdata_o;
    logic [NN-1:0]  narrow_q_ready_o, narrow_p_valid_o, bank_cs_o, bank_wen_o;
    logic [NN*AW-1:0] bank_addr_o;
    logic [63:0]    bank_be_o;

    hemaia_superbank_arbiter #(
        .NarrowDataWidth (NDW),
        .WideDataWidth   (WDW),
        .NumNarrow       (NN),
        .AddrWidth       (AW),
        .MemLatency      (LAT),
        .MaxWideStreak   (MAXS)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .wide_q_valid_i   (wqv),
        .wide_q_ready_o   (wide_q_ready_o),
        .wide_q_addr_i    (wqa),
        .wide_q_write_i   (wqw),
        .wide_q_data_i    (wqd),
        .wide_q_strb_i    (wqs),
        .wide_p_valid_o   (wide_p_valid_o),
        .wide_p_data_o    (wide_p_data_o),
        .narrow_q_valid_i (nqv),
        .narrow_q_ready_o (narrow_q_ready_o),
        .narrow_q_addr_i  (nqa),
        .narrow_q_write_i (nqw),
        .narrow_q_data_i  (nqd),
        .narrow_q_strb_i  (nqs),
        .narrow_p_valid_o (narrow_p_valid_o),
        .narrow_p_data_o  (narrow_p_data_o),
        .bank_cs_o        (bank_cs_o),
        .bank_wen_o       (bank_wen_o),
        .bank_addr_o      (bank_addr_o),
        .bank_be_o        (bank_be_o),
        .bank_wdata_o     (bank_wdata_o),
        .bank_rdata_i     (rd_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wide_run = 0;
    bit          sched_w [int];
    logic [7:0]  sched_n [int];

    logic         e_wready, e_wpv;
    logic [7:0]   e_nready, e_cs, e_wen, e_npv;
    logic [79:0]  e_addr;
    logic [63:0]  e_be;
    logic [511:0] e_wdata;

    typedef struct packed {
        logic        wv;
        logic        ww;
        logic [9:0]  wa;
        logic [63:0] ws;
        logic [7:0]  nv;
        logic [7:0]  nw;
        logic        exp_wready;
        logic [7:0]  exp_nready;
        logic [7:0]  exp_cs;
        logic [63:0] exp_be;
        logic        exp_wpv;
        logic [7:0]  exp_npv;
    } vec_t;

    vec_t tbl [13];

    task automatic checkField(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs derived from the arbitration rules and the response schedule.
    task automatic computeExpected();
        logic pend, wins;
        pend     = |nqv;
        wins     = wqv && (!pend || wide_run < MAXS);
        e_wready = wins;
        e_nready = wins ? 8'h0 : nqv;
        e_cs = '0; e_wen = '0; e_addr = '0; e_be = '0; e_wdata = '0;
        for (int j = 0; j < NN; j++) begin
            if (wins) begin
                e_cs[j] = 1'b1;
                e_wen[j] = wqw;
                e_addr[j*AW +: AW] = wqa;
                e_be[j*8 +: 8] = wqs[j*8 +: 8];
                e_wdata[j*64 +: 64] = wqd[j*64 +: 64];
            end else if (nqv[j]) begin
                e_cs[j] = 1'b1;
                e_wen[j] = nqw[j];
                e_addr[j*AW +: AW] = nqa[j*AW +: AW];
                e_be[j*8 +: 8] = nqs[j*8 +: 8];
                e_wdata[j*64 +: 64] = nqd[j*64 +: 64];
            end
        end
        e_wpv = rst_n && sched_w.exists(cyc);
        e_npv = (rst_n && sched_n.exists(cyc)) ? sched_n[cyc] : 8'h0;
    endtask

    task automatic checkOutput();
        computeExpected();
        checkField("wide_ready",   512'(wide_q_ready_o),   512'(e_wready));
        checkField("narrow_ready", 512'(narrow_q_ready_o), 512'(e_nready));
        checkField("bank_cs",      512'(bank_cs_o),        512'(e_cs));
        checkField("bank_wen",     512'(bank_wen_o),       512'(e_wen));
        checkField("bank_addr",    512'(bank_addr_o),      512'(e_addr));
        checkField("bank_be",      512'(bank_be_o),        512'(e_be));
        checkField("bank_wdata",   bank_wdata_o,           e_wdata);
        checkField("wide_pvalid",  512'(wide_p_valid_o),   512'(e_wpv));
        checkField("narrow_pvalid", 512'(narrow_p_valid_o), 512'(e_npv));
        if (e_wpv) checkField("wide_rdata", wide_p_data_o, rd_bus);
        for (int j = 0; j < NN; j++) begin
            if (e_npv[j]) checkField("narrow_rdata", 512'(narrow_p_data_o[j*64 +: 64]), 512'(rd_bus[j*64 +: 64]));
        end
    endtask

    task automatic modelEdge();
        logic pend;
        if (rst_n) begin
            computeExpected();
            pend = |nqv;
            if (e_wready) sched_w[cyc + LAT] = 1'b1;
            else if (pend) sched_n[cyc + LAT] = nqv;
            if (pend && e_wready) wide_run = (wide_run < MAXS) ? wide_run + 1 : MAXS;
            else wide_run = 0;
        end
        cyc++;
    endtask

    task automatic modelReset();
        sched_w.delete();
        sched_n.delete();
        wide_run = 0;
    endtask

    task automatic applyStimulus(input logic wv, input logic ww, input logic [9:0] wa, input logic [63:0] ws,
                                 input logic [7:0] nv, input logic [7:0] nw, input logic [511:0] wd,
                                 input logic [79:0] na, input logic [511:0] nd, input logic [63:0] ns,
                                 input logic [511:0] rd);
        wqv = wv; wqw = ww; wqa = wa; wqs = ws; wqd = wd;
        nqv = nv; nqw = nw; nqa = na; nqd = nd; nqs = ns;
        rd_bus = rd;
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BE21  = 64'h0000_FF00_0000_00FF;
    localparam logic [63:0] BE04  = 64'h0000_0000_00FF_0000;

    initial begin
        logic [511:0] rd_tab, nd_tab;
        logic [79:0]  na_tab;
        logic [5:0]   wide_pat;

        tbl[0]  = '{1'b1, 1'b0, 10'h012, ONES,  8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 10'h000, ONES,  8'h21, 8'h21, 1'b0, 8'h21, 8'h21, BE21,  1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 10'h040, ONES,  8'h04, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 10'h040, ONES,  8'h04, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b1, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 10'h040, ONES,  8'h04, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b0, 8'h21};
        tbl[5]  = '{1'b1, 1'b1, 10'h040, ONES,  8'h04, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b1, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 10'h040, ONES,  8'h04, 8'h00, 1'b0, 8'h04, 8'h04, BE04,  1'b1, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 10'h041, ONES,  8'h04, 8'h00, 1'b1, 8'h00, 8'hFF, ONES,  1'b1, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 10'h000, ONES,  8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 10'h033, 64'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 64'hFF, 1'b0, 8'h04};
        tbl[10] = '{1'b0, 1'b0, 10'h000, ONES,  8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 10'h000, ONES,  8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 10'h000, ONES,  8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'h00};

        for (int j = 0; j < NN; j++) begin
            rd_tab[j*64 +: 64] = 64'(j);
            nd_tab[j*64 +: 64] = 64'(j + 16);
            na_tab[j*AW +: AW] = 10'h003;
        end
        nd_tab[0*64 +: 64] = 64'hAA;
        nd_tab[5*64 +: 64] = 64'h55;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, rd_tab);
        #1;
        runCycle();
        applyStimulus(1'b1, 1'b0, 10'h3FF, ONES, 8'h00, 8'h00, rnd512(), na_tab, nd_tab, ONES, rd_tab);
        runCycle();
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].wv, tbl[i].ww, tbl[i].wa, tbl[i].ws, tbl[i].nv, tbl[i].nw,
                          rnd512(), na_tab, nd_tab, ONES, rd_tab);
            @(negedge clk);
            checkOutput();
            checkField("tbl_wready", 512'(wide_q_ready_o),   512'(tbl[i].exp_wready));
            checkField("tbl_nready", 512'(narrow_q_ready_o), 512'(tbl[i].exp_nready));
            checkField("tbl_cs",     512'(bank_cs_o),        512'(tbl[i].exp_cs));
            checkField("tbl_be",     512'(bank_be_o),        512'(tbl[i].exp_be));
            checkField("tbl_wpv",    512'(wide_p_valid_o),   512'(tbl[i].exp_wpv));
            checkField("tbl_npv",    512'(narrow_p_valid_o), 512'(tbl[i].exp_npv));
            if (tbl[i].exp_wpv) checkField("tbl_wdata_slice7", 512'(wide_p_data_o[7*64 +: 64]), 512'(7));
            @(posedge clk);
            modelEdge();
            #1;
        end

        $display("[TB] reset with responses in flight");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b0, 10'h055, ONES, 8'h04, 8'h00, rnd512(), na_tab, nd_tab, ONES, rnd512());
            runCycle();
        end
        rst_n = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, rnd512());
        runCycle();
        rst_n = 1'b1;
        wide_pat = 6'b101111;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 10'h066, ONES, 8'h04, 8'h00, rnd512(), na_tab, nd_tab, ONES, rnd512());
            @(negedge clk);
            checkOutput();
            checkField("rst_streak_wready", 512'(wide_q_ready_o), 512'(wide_pat[k]));
            if (k < LAT) checkField("rst_no_stale_pvalid", 512'({wide_p_valid_o, narrow_p_valid_o}), 512'(0));
            @(posedge clk);
            modelEdge();
            #1;
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++) begin
            logic [7:0] nv;
            logic [79:0] na;
            nv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom);
            for (int j = 0; j < NN; j++) na[j*AW +: AW] = 10'($urandom);
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), 10'($urandom), {$urandom, $urandom},
                          nv, 8'($urandom), rnd512(), na, rnd512(), {$urandom, $urandom}, rnd512());
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                modelReset();
                runCycle();
                rst_n = 1'b1;
            end else begin
                runCycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
